// File: rtl/puf_pkg.sv
// Shared types, mode codes and the response function for the PUF emulator.
// Latency: n/a (declarations and a pure combinational function only).
// Backpressure: n/a.
package puf_pkg;

    // Widest challenge supported by puf_response; N_BITS must not exceed this.
    localparam int PUF_MAX_BITS = 256;

    localparam logic [1:0] MODE_LEGACY  = 2'd0;
    localparam logic [1:0] MODE_XOR     = 2'd1;
    localparam logic [1:0] MODE_ARBITER = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        READY = 2'd2
    } state_t;

    typedef struct packed {
        logic [PUF_MAX_BITS-1:0] top;
        logic [PUF_MAX_BITS-1:0] bot;
    } resp_t;

    // Inputs are zero-padded to PUF_MAX_BITS; only bits [n_bits-1:0] of the
    // result are meaningful. Mode 3 is reserved and falls back to LEGACY.
    function automatic resp_t puf_response(input logic [PUF_MAX_BITS-1:0] a,
                                           input logic [PUF_MAX_BITS-1:0] b,
                                           input logic [1:0]              mode,
                                           input int                      n_bits);
        resp_t                   r;
        logic [PUF_MAX_BITS-1:0] x;
        logic                    p;
        r = '0;
        x = a ^ b;
        p = 1'b0;
        case (mode)
            MODE_XOR: begin
                r.top = x;
                r.bot = ~x;
            end
            MODE_ARBITER: begin
                // Prefix parity: padding bits are zero so they never disturb it.
                for (int i = 0; i < PUF_MAX_BITS; i++) begin
                    p        = p ^ x[i];
                    r.top[i] = p;
                end
                // Bottom chain is the top chain read back-to-front.
                for (int i = 0; i < PUF_MAX_BITS; i++) begin
                    if (i < n_bits) begin
                        r.bot[i] = r.top[n_bits-1-i];
                    end
                end
            end
            default: begin
                r.top = a | b;
                r.bot = a & b;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/puf_emulator_core_if.sv
// Host-side serial challenge/response bundle for the PUF emulator.
// Latency: n/a (wires only).
// Backpressure: none; the host paces everything with load_en/trig/out_en.
interface puf_emulator_core_if;
    logic       ca_si;
    logic       cb_si;
    logic       load_en;
    logic       trig;
    logic [1:0] mode;
    logic       out_en;
    logic       so_up;
    logic       so_not_up;
    logic       so_down;
    logic       so_not_down;
    logic       so_valid;
    logic       busy;

    modport master (
        output ca_si, cb_si, load_en, trig, mode, out_en,
        input  so_up, so_not_up, so_down, so_not_down, so_valid, busy
    );

    modport slave (
        input  ca_si, cb_si, load_en, trig, mode, out_en,
        output so_up, so_not_up, so_down, so_not_down, so_valid, busy
    );
endinterface

// File: rtl/puf_response_calc.sv
// Combinational top/bot response of an N_BITS challenge pair for a given mode.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module puf_response_calc
    import puf_pkg::*;
#(
    parameter int N_BITS = 128
) (
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    input  logic [1:0]        mode,
    output logic [N_BITS-1:0] top,
    output logic [N_BITS-1:0] bot
);

    resp_t resp;
    // Bits above N_BITS are padding and intentionally discarded.
    resp_t resp_unused;

    // Evaluate the shared response function on the zero-padded challenge.
    always_comb begin
        resp = puf_response(PUF_MAX_BITS'(a), PUF_MAX_BITS'(b), mode, N_BITS);
    end

    assign resp_unused = resp;
    assign top         = resp.top[N_BITS-1:0];
    assign bot         = resp.bot[N_BITS-1:0];

endmodule

// File: rtl/puf_emulator_core.sv
// Software PUF model: serial challenge load, trig-started evaluation, serial readout.
// Latency: so_valid rises EVAL_CYCLES clocks after the edge that samples a trig rise.
// Backpressure: none; load_en ignored in EVAL, out_en ignored outside READY.
module puf_emulator_core
    import puf_pkg::*;
#(
    parameter  int N_BITS      = 128,
    parameter  int EVAL_CYCLES = 4,
    localparam int CNT_W       = $clog2(N_BITS)
) (
    input  logic                clk,
    input  logic                reset,
    puf_emulator_core_if.slave  bus
);

    localparam int EW = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;

    state_t            state;
    state_t            state_nxt;
    logic              trig_q;
    logic              trig_rise;
    logic [EW-1:0]     eval_cnt;
    logic              eval_last;
    logic [CNT_W-1:0]  chal_idx;
    logic [CNT_W-1:0]  resp_idx;
    logic [1:0]        mode_q;
    logic [N_BITS-1:0] a_buf;
    logic [N_BITS-1:0] b_buf;
    logic [N_BITS-1:0] top_buf;
    logic [N_BITS-1:0] bot_buf;
    logic [N_BITS-1:0] calc_top;
    logic [N_BITS-1:0] calc_bot;
    logic              accept_trig;
    logic              accept_load;
    logic              accept_out;
    logic              out_last;

    assign trig_rise   = bus.trig & ~trig_q;
    assign accept_trig = trig_rise && (state != EVAL);
    // Challenge buffers are frozen while the response is being computed.
    assign accept_load = bus.load_en && (state != EVAL);
    // A simultaneous trig rise aborts the readout, so out_en loses to it.
    assign accept_out  = bus.out_en && (state == READY) && !trig_rise;
    assign out_last    = (resp_idx == CNT_W'(N_BITS-1));
    assign eval_last   = (state == EVAL) && (eval_cnt == EW'(EVAL_CYCLES-1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_trig) state_nxt = EVAL;
            end
            EVAL: begin
                if (eval_last) state_nxt = READY;
            end
            READY: begin
                if (trig_rise)                    state_nxt = EVAL;
                else if (bus.out_en && out_last)  state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Edge detector history for trig, sampled every clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= bus.trig;
        end
    end

    // Evaluation timer: restarts on every accepted trig.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eval_cnt <= '0;
        end else if (accept_trig || eval_last) begin
            eval_cnt <= '0;
        end else if (state == EVAL) begin
            eval_cnt <= eval_cnt + EW'(1);
        end
    end

    // Challenge write and index; a load in the trig cycle lands before the index clears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_buf    <= '0;
            b_buf    <= '0;
            chal_idx <= '0;
        end else begin
            if (accept_load) begin
                a_buf[chal_idx] <= bus.ca_si;
                b_buf[chal_idx] <= bus.cb_si;
            end
            if (accept_trig) begin
                chal_idx <= '0;
            end else if (accept_load) begin
                chal_idx <= (chal_idx == CNT_W'(N_BITS-1)) ? '0 : chal_idx + CNT_W'(1);
            end
        end
    end

    // Mode is captured once per evaluation so it cannot change mid-flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= MODE_LEGACY;
        end else if (accept_trig) begin
            mode_q <= bus.mode;
        end
    end

    puf_response_calc #(
        .N_BITS (N_BITS)
    ) u_calc (
        .a    (a_buf),
        .b    (b_buf),
        .mode (mode_q),
        .top  (calc_top),
        .bot  (calc_bot)
    );

    // Response buffers load on the final evaluation clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_buf <= '0;
            bot_buf <= '0;
        end else if (eval_last) begin
            top_buf <= calc_top;
            bot_buf <= calc_bot;
        end
    end

    // Readout index: cleared on trig, wraps after the last bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_idx <= '0;
        end else if (accept_trig) begin
            resp_idx <= '0;
        end else if (accept_out) begin
            resp_idx <= out_last ? '0 : resp_idx + CNT_W'(1);
        end
    end

    // Serial outputs depend only on registered state, so they change one clock after out_en.
    assign bus.so_up       = (state == READY) & top_buf[resp_idx];
    assign bus.so_down     = (state == READY) & bot_buf[resp_idx];
    assign bus.so_not_up   = ~bus.so_up;
    assign bus.so_not_down = ~bus.so_down;
    assign bus.so_valid    = (state == READY);
    assign bus.busy        = (state == EVAL);

endmodule

// File: tb/tb_puf_emulator_core.sv
// Self-checking bench for puf_emulator_core with N_BITS=8, EVAL_CYCLES=3.
// Latency: n/a.
// Backpressure: n/a.
module tb_puf_emulator_core;

    localparam int N  = 8;
    localparam int EC = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    puf_emulator_core_if bus ();

    puf_emulator_core #(
        .N_BITS      (N),
        .EVAL_CYCLES (EC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state: challenge bits, write pointer and the expected response.
    bit [N-1:0] m_a;
    bit [N-1:0] m_b;
    int         m_idx;
    bit [N-1:0] exp_top;
    bit [N-1:0] exp_bot;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Response rules written directly from the mode table.
    function automatic bit [2*N-1:0] ref_resp(input bit [N-1:0] a, input bit [N-1:0] b, input int mode);
        bit [N-1:0] t;
        bit [N-1:0] d;
        int         x;
        x = int'(a ^ b);
        case (mode)
            1: begin
                t = a ^ b;
                d = ~(a ^ b);
            end
            2: begin
                for (int i = 0; i < N; i++) t[i] = ($countones(x & ((1 << (i + 1)) - 1)) % 2) == 1;
                for (int i = 0; i < N; i++) d[i] = t[N-1-i];
            end
            default: begin
                t = a | b;
                d = a & b;
            end
        endcase
        return {t, d};
    endfunction

    task automatic model_load(input bit ab, input bit bb);
        m_a[m_idx] = ab;
        m_b[m_idx] = bb;
        m_idx      = (m_idx + 1) % N;
    endtask

    task automatic model_clear();
        m_a   = '0;
        m_b   = '0;
        m_idx = 0;
    endtask

    task automatic drive_load(input bit ab, input bit bb);
        bus.load_en = 1'b1;
        bus.ca_si   = ab;
        bus.cb_si   = bb;
        step();
        bus.load_en = 1'b0;
        model_load(ab, bb);
    endtask

    // Trigger from IDLE/READY and measure the latency to so_valid.
    task automatic trig_eval(input int mode, input bit noisy);
        int cyc;
        int busy_cnt;
        bus.trig = 1'b1;
        bus.mode = 2'(mode);
        {exp_top, exp_bot} = ref_resp(m_a, m_b, mode);
        m_idx = 0;
        step();
        bus.trig = 1'b0;
        cyc      = 0;
        busy_cnt = 0;
        while (bus.so_valid !== 1'b1 && cyc < 20) begin
            if (bus.busy === 1'b1) busy_cnt++;
            // Loads during EVAL must be ignored by the core.
            bus.load_en = noisy;
            bus.ca_si   = 1'($urandom);
            bus.cb_si   = 1'($urandom);
            step();
            cyc++;
        end
        bus.load_en = 1'b0;
        n_vec++;
        if (cyc !== EC) begin
            n_err++;
            $display("FAIL eval_latency: got %0d clocks want %0d", cyc, EC);
        end
        n_vec++;
        if (busy_cnt !== EC) begin
            n_err++;
            $display("FAIL busy_cycles: got %0d want %0d", busy_cnt, EC);
        end
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_in_ready: got %b want 0", bus.busy);
        end
    endtask

    // Shift out nbits of the response; a full readout must end in IDLE.
    task automatic do_readout(input int nbits, input bit loads);
        bit ld;
        bit la;
        bit lb;
        for (int i = 0; i < nbits; i++) begin
            n_vec++;
            if (bus.so_valid !== 1'b1) begin
                n_err++;
                $display("FAIL rd_valid[%0d]: got %b want 1", i, bus.so_valid);
            end
            n_vec++;
            if (bus.so_up !== exp_top[i]) begin
                n_err++;
                $display("FAIL rd_up[%0d]: got %b want %b", i, bus.so_up, exp_top[i]);
            end
            n_vec++;
            if (bus.so_down !== exp_bot[i]) begin
                n_err++;
                $display("FAIL rd_down[%0d]: got %b want %b", i, bus.so_down, exp_bot[i]);
            end
            n_vec++;
            if (bus.so_not_up !== ~exp_top[i] || bus.so_not_down !== ~exp_bot[i]) begin
                n_err++;
                $display("FAIL rd_not[%0d]: got %b%b want %b%b", i, bus.so_not_up, bus.so_not_down,
                         ~exp_top[i], ~exp_bot[i]);
            end
            ld = loads ? 1'($urandom) : 1'b0;
            la = 1'($urandom);
            lb = 1'($urandom);
            bus.out_en  = 1'b1;
            bus.load_en = ld;
            bus.ca_si   = la;
            bus.cb_si   = lb;
            step();
            bus.out_en  = 1'b0;
            bus.load_en = 1'b0;
            if (ld) model_load(la, lb);
        end
        if (nbits == N) begin
            n_vec++;
            if (bus.so_valid !== 1'b0 || bus.busy !== 1'b0) begin
                n_err++;
                $display("FAIL rd_end_state: got valid=%b busy=%b want 0 0", bus.so_valid, bus.busy);
            end
            n_vec++;
            if (bus.so_up !== 1'b0 || bus.so_down !== 1'b0 || bus.so_not_up !== 1'b1 || bus.so_not_down !== 1'b1) begin
                n_err++;
                $display("FAIL rd_end_idle_out: got %b%b%b%b want 0011", bus.so_up, bus.so_down,
                         bus.so_not_up, bus.so_not_down);
            end
        end
    endtask

    task automatic test_reset();
        bus.ca_si   = 1'b0;
        bus.cb_si   = 1'b0;
        bus.load_en = 1'b0;
        bus.trig    = 1'b0;
        bus.mode    = 2'd0;
        bus.out_en  = 1'b0;
        reset       = 1'b1;
        model_clear();
        step();
        step();
        n_vec++;
        if ({bus.so_up, bus.so_not_up, bus.so_down, bus.so_not_down} !== 4'b0101) begin
            n_err++;
            $display("FAIL reset_so: got %b want 0101", {bus.so_up, bus.so_not_up, bus.so_down, bus.so_not_down});
        end
        n_vec++;
        if (bus.so_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_status: got valid=%b busy=%b want 0 0", bus.so_valid, bus.busy);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_zero_run();
        trig_eval(0, 1'b0);
        do_readout(N, 1'b0);
    endtask

    // Fixed challenge A=0xA5, B=0x0F against the known answers for modes 0..2.
    task automatic test_modes();
        bit [7:0] ca;
        bit [7:0] cb;
        bit [7:0] k_top [3];
        bit [7:0] k_bot [3];
        ca = 8'hA5;
        cb = 8'h0F;
        k_top = '{8'hAF, 8'hAA, 8'h66};
        k_bot = '{8'h05, 8'h55, 8'h66};
        for (int i = 0; i < N; i++) drive_load(ca[i], cb[i]);
        for (int m = 0; m < 3; m++) begin
            trig_eval(m, 1'b0);
            exp_top = k_top[m];
            exp_bot = k_bot[m];
            do_readout(N, 1'b0);
        end
    endtask

    task automatic test_trig_timing();
        int cyc;
        // A second rise during EVAL must not extend or restart evaluation.
        bus.trig = 1'b1;
        bus.mode = 2'd1;
        {exp_top, exp_bot} = ref_resp(m_a, m_b, 1);
        m_idx = 0;
        step();
        bus.trig = 1'b0;
        step();
        bus.trig = 1'b1;
        step();
        bus.trig = 1'b0;
        n_vec++;
        if (bus.so_valid !== 1'b0 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL retrig_eval_mid: got valid=%b busy=%b want 0 1", bus.so_valid, bus.busy);
        end
        step();
        n_vec++;
        if (bus.so_valid !== 1'b1) begin
            n_err++;
            $display("FAIL retrig_eval_latency: got valid=%b want 1", bus.so_valid);
        end
        do_readout(N, 1'b0);

        // A held-high trig starts one evaluation only.
        bus.trig = 1'b1;
        bus.mode = 2'd2;
        {exp_top, exp_bot} = ref_resp(m_a, m_b, 2);
        m_idx = 0;
        step();
        cyc = 0;
        while (bus.so_valid !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        n_vec++;
        if (cyc !== EC) begin
            n_err++;
            $display("FAIL held_trig_latency: got %0d want %0d", cyc, EC);
        end
        step();
        step();
        n_vec++;
        if (bus.so_valid !== 1'b1 || bus.busy !== 1'b0 || bus.so_up !== exp_top[0]) begin
            n_err++;
            $display("FAIL held_trig_no_retrig: got valid=%b busy=%b up=%b want 1 0 %b",
                     bus.so_valid, bus.busy, bus.so_up, exp_top[0]);
        end
        bus.trig = 1'b0;
        step();
        do_readout(N, 1'b0);
    endtask

    // trig together with out_en mid-readout aborts and restarts from bit 0.
    task automatic test_trig_mid_readout();
        int cyc;
        trig_eval(0, 1'b0);
        do_readout(3, 1'b0);
        bus.trig   = 1'b1;
        bus.out_en = 1'b1;
        bus.mode   = 2'd0;
        {exp_top, exp_bot} = ref_resp(m_a, m_b, 0);
        m_idx = 0;
        step();
        bus.trig   = 1'b0;
        bus.out_en = 1'b0;
        cyc = 0;
        while (bus.so_valid !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        n_vec++;
        if (cyc !== EC) begin
            n_err++;
            $display("FAIL abort_gap: got %0d clocks want %0d", cyc, EC);
        end
        do_readout(N, 1'b0);
    endtask

    // Ten loads: bits 8 and 9 are forced to differ from bits 0 and 1.
    task automatic test_load_wrap();
        bit a0;
        bit b0;
        bit a1;
        bit b1;
        a0 = 1'($urandom);
        b0 = 1'($urandom);
        a1 = 1'($urandom);
        b1 = 1'($urandom);
        drive_load(a0, b0);
        drive_load(a1, b1);
        for (int i = 2; i < N; i++) drive_load(1'($urandom), 1'($urandom));
        drive_load(~a0, ~b0);
        drive_load(~a1, ~b1);
        trig_eval(1, 1'b0);
        do_readout(N, 1'b0);
        trig_eval(0, 1'b0);
        do_readout(N, 1'b0);
    endtask

    task automatic test_reset_mid_eval();
        for (int i = 0; i < N; i++) drive_load(1'($urandom), 1'($urandom));
        bus.trig = 1'b1;
        bus.mode = 2'd1;
        step();
        bus.trig = 1'b0;
        step();
        #1;
        reset = 1'b1;
        #1;
        n_vec++;
        if (bus.so_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_eval: got valid=%b busy=%b want 0 0", bus.so_valid, bus.busy);
        end
        model_clear();
        step();
        reset = 1'b0;
        step();
        trig_eval(0, 1'b0);
        do_readout(N, 1'b0);
        trig_eval(2, 1'b0);
        do_readout(N, 1'b0);
    endtask

    task automatic test_random();
        int nl;
        for (int it = 0; it < 24; it++) begin
            nl = $urandom_range(0, 12);
            for (int i = 0; i < nl; i++) drive_load(1'($urandom), 1'($urandom));
            trig_eval($urandom_range(0, 3), 1'b1);
            do_readout(N, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_zero_run();
        test_modes();
        test_trig_timing();
        test_trig_mid_readout();
        test_load_wrap();
        test_reset_mid_eval();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
